// File: rtl/mips_cpu.sv
// mips_cpu: single-cycle MIPS-32 subset core with an optional CP0-lite block.
// Instruction and data memories sit outside the core and are reached through
// the i_/m_ ports. The w_/m_ trace ports show every retired register or
// memory write.
// Define MIPS_CP0_EN to build the SR/Cause/EPC registers, the external
// interrupt, and mfc0/mtc0/eret. When it is undefined, those three
// instructions are nops and the interrupt input is ignored.
module mips_cpu #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] DM_TOP    = 32'h0000_2FFF,
    parameter logic [31:0] INT_ADDR  = 32'h0000_7F20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    output logic [31:0] macroscopic_pc,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] m_data_addr,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_int_addr,
    output logic [3:0]  m_int_byteen,
    output logic [31:0] m_inst_addr,
    output logic        w_grf_we,
    output logic [4:0]  w_grf_addr,
    output logic [31:0] w_grf_wdata,
    output logic [31:0] w_inst_addr
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_COP0 = 6'h10;
    localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23;
    localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00, FN_JR = 6'h08, FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] sext8(input logic [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

    logic [31:0] pc_r;
    logic [31:0] grf_r [0:31];
    logic [5:0]  op_s, funct_s;
    logic [4:0]  rs_s, rt_s, rd_s, shamt_s;
    logic [31:0] rs_val_s, rt_val_s, imm_sext_s, addr_s, pc_plus4_s;
    logic [31:0] seq_pc_s, pc_next_s, load_half_s, load_byte_s;
    logic [31:0] grf_wdata_s, st_wdata_s, cp0_rdata_s, epc_s;
    logic [4:0]  grf_waddr_s;
    logic [3:0]  st_be_s;
    logic        grf_we_s, cp0_en_s, int_take_s, dm_sel_s, int_sel_s;
    logic        is_mfc0_s, is_mtc0_s, is_eret_s;

    assign op_s       = i_inst_rdata[31:26];
    assign rs_s       = i_inst_rdata[25:21];
    assign rt_s       = i_inst_rdata[20:16];
    assign rd_s       = i_inst_rdata[15:11];
    assign shamt_s    = i_inst_rdata[10:6];
    assign funct_s    = i_inst_rdata[5:0];
    assign imm_sext_s = sext16(i_inst_rdata[15:0]);
    assign rs_val_s   = (rs_s == 5'd0) ? 32'd0 : grf_r[rs_s];
    assign rt_val_s   = (rt_s == 5'd0) ? 32'd0 : grf_r[rt_s];
    assign addr_s     = rs_val_s + imm_sext_s;
    assign pc_plus4_s = pc_r + 32'd4;

    assign is_mfc0_s = cp0_en_s & (op_s == OP_COP0) & (rs_s == 5'b00000);
    assign is_mtc0_s = cp0_en_s & (op_s == OP_COP0) & (rs_s == 5'b00100);
    assign is_eret_s = cp0_en_s & (i_inst_rdata == 32'h4200_0018);

`ifdef MIPS_CP0_EN
    logic [31:0] sr_r, epc_r;

    assign cp0_en_s   = 1'b1;
    assign int_take_s = interrupt & sr_r[10] & sr_r[0] & ~sr_r[1];
    assign epc_s      = epc_r;

    // CP0 read port: SR, Cause (live interrupt in IP[10]) and EPC
    always_comb begin
        cp0_rdata_s = 32'd0;
        case (rd_s)
            5'd12:   cp0_rdata_s = sr_r;
            5'd13:   cp0_rdata_s = {21'd0, interrupt, 10'd0};
            5'd14:   cp0_rdata_s = epc_r;
            default: cp0_rdata_s = 32'd0;
        endcase
    end

    // CP0 state: interrupt entry outranks eret and mtc0 of the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_r  <= 32'd0;
            epc_r <= 32'd0;
        end else if (int_take_s) begin
            epc_r    <= pc_r;
            sr_r[1]  <= 1'b1;
        end else if (is_eret_s) begin
            sr_r[1]  <= 1'b0;
        end else if (is_mtc0_s && rd_s == 5'd12) begin
            sr_r     <= rt_val_s & 32'h0000_FC03;
        end else if (is_mtc0_s && rd_s == 5'd14) begin
            epc_r    <= rt_val_s;
        end
    end
`else
    assign cp0_en_s    = 1'b0;
    assign int_take_s  = interrupt & 1'b0;
    assign epc_s       = 32'd0;
    assign cp0_rdata_s = 32'd0;
`endif

    // Load extraction: halfword by addr[1], byte by addr[1:0], sign-extended
    always_comb begin
        load_half_s = addr_s[1] ? sext16(m_data_rdata[31:16]) : sext16(m_data_rdata[15:0]);
        load_byte_s = 32'd0;
        case (addr_s[1:0])
            2'd0:    load_byte_s = sext8(m_data_rdata[7:0]);
            2'd1:    load_byte_s = sext8(m_data_rdata[15:8]);
            2'd2:    load_byte_s = sext8(m_data_rdata[23:16]);
            2'd3:    load_byte_s = sext8(m_data_rdata[31:24]);
            default: load_byte_s = 32'd0;
        endcase
    end

    // Main decode: GRF write, store lanes and sequential next PC
    always_comb begin
        seq_pc_s    = pc_plus4_s;
        grf_we_s    = 1'b0;
        grf_waddr_s = rt_s;
        grf_wdata_s = 32'd0;
        st_be_s     = 4'b0000;
        st_wdata_s  = rt_val_s;
        case (op_s)
            OP_RTYPE: begin
                grf_waddr_s = rd_s;
                case (funct_s)
                    FN_ADDU: begin grf_we_s = 1'b1; grf_wdata_s = rs_val_s + rt_val_s; end
                    FN_SUBU: begin grf_we_s = 1'b1; grf_wdata_s = rs_val_s - rt_val_s; end
                    FN_AND:  begin grf_we_s = 1'b1; grf_wdata_s = rs_val_s & rt_val_s; end
                    FN_OR:   begin grf_we_s = 1'b1; grf_wdata_s = rs_val_s | rt_val_s; end
                    FN_SLT:  begin
                        grf_we_s    = 1'b1;
                        grf_wdata_s = {31'd0, $signed(rs_val_s) < $signed(rt_val_s)};
                    end
                    FN_SLL:  begin grf_we_s = 1'b1; grf_wdata_s = rt_val_s << shamt_s; end
                    FN_JR:   seq_pc_s = rs_val_s;
                    default: grf_we_s = 1'b0;
                endcase
            end
            OP_ORI:   begin grf_we_s = 1'b1; grf_wdata_s = rs_val_s | {16'd0, i_inst_rdata[15:0]}; end
            OP_ADDIU: begin grf_we_s = 1'b1; grf_wdata_s = rs_val_s + imm_sext_s; end
            OP_LUI:   begin grf_we_s = 1'b1; grf_wdata_s = {i_inst_rdata[15:0], 16'd0}; end
            OP_LW:    begin grf_we_s = 1'b1; grf_wdata_s = m_data_rdata; end
            OP_LH:    begin grf_we_s = 1'b1; grf_wdata_s = load_half_s; end
            OP_LB:    begin grf_we_s = 1'b1; grf_wdata_s = load_byte_s; end
            OP_SW:    st_be_s = 4'b1111;
            OP_SH:    begin
                st_be_s    = addr_s[1] ? 4'b1100 : 4'b0011;
                st_wdata_s = {2{rt_val_s[15:0]}};
            end
            OP_SB:    begin
                st_be_s    = 4'b0001 << addr_s[1:0];
                st_wdata_s = {4{rt_val_s[7:0]}};
            end
            OP_BEQ:   begin
                if (rs_val_s == rt_val_s) seq_pc_s = pc_plus4_s + {imm_sext_s[29:0], 2'b00};
                else                      seq_pc_s = pc_plus4_s;
            end
            OP_BNE:   begin
                if (rs_val_s != rt_val_s) seq_pc_s = pc_plus4_s + {imm_sext_s[29:0], 2'b00};
                else                      seq_pc_s = pc_plus4_s;
            end
            OP_J:     seq_pc_s = {pc_r[31:28], i_inst_rdata[25:0], 2'b00};
            OP_JAL:   begin
                seq_pc_s    = {pc_r[31:28], i_inst_rdata[25:0], 2'b00};
                grf_we_s    = 1'b1;
                grf_waddr_s = 5'd31;
                grf_wdata_s = pc_plus4_s;
            end
            OP_COP0:  begin
                if (is_mfc0_s) begin
                    grf_we_s    = 1'b1;
                    grf_wdata_s = cp0_rdata_s;
                end else if (is_eret_s) begin
                    seq_pc_s = epc_s;
                end else begin
                    seq_pc_s = pc_plus4_s;
                end
            end
            default:  grf_we_s = 1'b0;
        endcase
    end

    assign pc_next_s = int_take_s ? EXC_ENTRY : seq_pc_s;
    assign dm_sel_s  = (addr_s <= DM_TOP);
    assign int_sel_s = (addr_s[31:2] == INT_ADDR[31:2]);

    assign macroscopic_pc = pc_r;
    assign i_inst_addr    = pc_r;
    assign m_data_addr    = addr_s;
    assign m_int_addr     = addr_s;
    assign m_data_wdata   = st_wdata_s;
    assign m_data_byteen  = (reset | int_take_s | ~dm_sel_s) ? 4'b0000 : st_be_s;
    assign m_int_byteen   = (reset | int_take_s | ~int_sel_s) ? 4'b0000 : st_be_s;
    assign m_inst_addr    = pc_r;
    assign w_grf_we       = grf_we_s & ~int_take_s & ~reset;
    assign w_grf_addr     = grf_waddr_s;
    assign w_grf_wdata    = grf_wdata_s;
    assign w_inst_addr    = pc_r;

    // Program counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_r <= PC_RESET;
        else       pc_r <= pc_next_s;
    end

    // Register file; $0 is never written so it always reads back zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) grf_r[i] <= 32'd0;
        end else if (w_grf_we && grf_waddr_s != 5'd0) begin
            grf_r[grf_waddr_s] <= grf_wdata_s;
        end
    end
endmodule

// File: tb/tb_mips_cpu.sv
// Directed bench for mips_cpu: a small program with hand-computed results,
// observed through the GRF and memory trace ports.
module tb_mips_cpu;
    logic        clk = 1'b0;
    logic        reset, interrupt;
    logic [31:0] macroscopic_pc, i_inst_addr, i_inst_rdata, m_data_addr, m_data_rdata;
    logic [31:0] m_data_wdata, m_int_addr, m_inst_addr, w_grf_wdata, w_inst_addr;
    logic [3:0]  m_data_byteen, m_int_byteen;
    logic        w_grf_we;
    logic [4:0]  w_grf_addr;
    logic [31:0] imem [0:2047];
    logic [31:0] dmem [0:1023];
    logic [31:0] imem_off;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mips_cpu dut (
        .clk(clk), .reset(reset), .interrupt(interrupt),
        .macroscopic_pc(macroscopic_pc), .i_inst_addr(i_inst_addr),
        .i_inst_rdata(i_inst_rdata), .m_data_addr(m_data_addr),
        .m_data_rdata(m_data_rdata), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_int_addr(m_int_addr),
        .m_int_byteen(m_int_byteen), .m_inst_addr(m_inst_addr),
        .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr),
        .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr)
    );

    assign imem_off     = i_inst_addr - 32'h0000_3000;
    assign i_inst_rdata = (imem_off < 32'h0000_1200) ? imem[imem_off[12:2]] : 32'd0;
    assign m_data_rdata = (m_data_addr < 32'h0000_1000) ? dmem[m_data_addr[11:2]] : 32'd0;

    // Data memory model: byte-lane writes at the rising edge
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (m_data_byteen[i] && m_data_addr < 32'h0000_1000)
                dmem[m_data_addr[11:2]][8*i +: 8] <= m_data_wdata[8*i +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        logic [31:0] off;
        off = addr - 32'h0000_3000;
        imem[off[12:2]] = word;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) imem[i] = 32'd0;
        for (int i = 0; i < 1024; i++) dmem[i] = 32'd0;
        put(32'h3000, 32'h3401_1234); // ori  $1,$0,0x1234
        put(32'h3004, 32'h3C02_AABB); // lui  $2,0xAABB
        put(32'h3008, 32'h3442_CCDD); // ori  $2,$2,0xCCDD
        put(32'h300C, 32'hA002_0005); // sb   $2,5($0)
        put(32'h3010, 32'h1000_0002); // beq  $0,$0,2
        put(32'h3014, 32'h3409_0BAD); // skipped
        put(32'h3018, 32'h3409_0BAD); // skipped
        put(32'h301C, 32'h8003_0005); // lb   $3,5($0)
        put(32'h3020, 32'h0C00_0C0A); // jal  0x3028
        put(32'h3024, 32'h3409_0BAD); // skipped
        put(32'h3028, 32'hAC02_7F20); // sw   $2,0x7F20($0)
        put(32'h302C, 32'h8405_0004); // lh   $5,4($0)
        put(32'h3030, 32'h0022_3021); // addu $6,$1,$2
        put(32'h3034, 32'h3408_0401); // ori  $8,$0,0x401
        put(32'h3038, 32'h4088_6000); // mtc0 $8,$12
        put(32'h303C, 32'h0041_382A); // slt  $7,$2,$1
        put(32'h3040, 32'h340A_0055); // ori  $10,$0,0x55
        put(32'h3044, 32'h0041_5823); // subu $11,$2,$1
        put(32'h3048, 32'h1400_0005); // bne  $0,$0,5
        put(32'h304C, 32'h0001_6100); // sll  $12,$1,4
        put(32'h3050, 32'h0041_6824); // and  $13,$2,$1
        put(32'h3054, 32'h240E_FFFF); // addiu $14,$0,-1
        put(32'h3058, 32'h8C0F_0004); // lw   $15,4($0)
        put(32'h305C, 32'hA401_0006); // sh   $1,6($0)
        put(32'h3060, 32'h03E0_0008); // jr   $31
        put(32'h4180, 32'h4004_7000); // mfc0 $4,$14
        put(32'h4184, 32'h4200_0018); // eret

        reset = 1'b1;
        interrupt = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pc", macroscopic_pc, 32'h0000_3000);
        check("rst_we", {31'd0, w_grf_we}, 32'd0);
        check("rst_dbe", {28'd0, m_data_byteen}, 32'd0);
        check("rst_ibe", {28'd0, m_int_byteen}, 32'd0);
        reset = 1'b0;
        #1;
        check("ori_we", {31'd0, w_grf_we}, 32'd1);
        check("ori_addr", {27'd0, w_grf_addr}, 32'd1);
        check("ori_data", w_grf_wdata, 32'h0000_1234);
        check("ori_iaddr", w_inst_addr, 32'h0000_3000);
        tick();
        check("lui_data", w_grf_wdata, 32'hAABB_0000);
        tick();
        check("ori2_data", w_grf_wdata, 32'hAABB_CCDD);
        tick();
        check("sb_addr", m_data_addr, 32'h0000_0005);
        check("sb_dbe", {28'd0, m_data_byteen}, 32'h0000_0002);
        check("sb_wdata", m_data_wdata, 32'hDDDD_DDDD);
        check("sb_ibe", {28'd0, m_int_byteen}, 32'd0);
        check("sb_we", {31'd0, w_grf_we}, 32'd0);
        check("sb_minst", m_inst_addr, 32'h0000_300C);
        tick();
        check("beq_we", {31'd0, w_grf_we}, 32'd0);
        tick();
        check("beq_pc", macroscopic_pc, 32'h0000_301C);
        check("lb_addr", {27'd0, w_grf_addr}, 32'd3);
        check("lb_data", w_grf_wdata, 32'hFFFF_FFDD);
        tick();
        check("jal_addr", {27'd0, w_grf_addr}, 32'd31);
        check("jal_data", w_grf_wdata, 32'h0000_3024);
        tick();
        check("jal_pc", macroscopic_pc, 32'h0000_3028);
        check("sw_ibe", {28'd0, m_int_byteen}, 32'h0000_000F);
        check("sw_dbe", {28'd0, m_data_byteen}, 32'd0);
        check("sw_wdata", m_data_wdata, 32'hAABB_CCDD);
        check("sw_iaddr", m_int_addr, 32'h0000_7F20);
        tick();
        check("lh_data", w_grf_wdata, 32'hFFFF_DD00);
        tick();
        check("addu_data", w_grf_wdata, 32'hAABB_DF11);
        tick();
        tick();
        check("mtc0_we", {31'd0, w_grf_we}, 32'd0);
        tick();
        check("slt_data", w_grf_wdata, 32'h0000_0001);
        tick();
        interrupt = 1'b1;
        #1;
`ifdef MIPS_CP0_EN
        check("int_we", {31'd0, w_grf_we}, 32'd0);
        check("int_dbe", {28'd0, m_data_byteen}, 32'd0);
        tick();
        check("int_pc", macroscopic_pc, 32'h0000_4180);
        interrupt = 1'b0;
        #1;
        check("mfc0_addr", {27'd0, w_grf_addr}, 32'd4);
        check("mfc0_data", w_grf_wdata, 32'h0000_3040);
        tick();
        check("eret_we", {31'd0, w_grf_we}, 32'd0);
        tick();
        check("eret_pc", macroscopic_pc, 32'h0000_3040);
        check("ori55_data", w_grf_wdata, 32'h0000_0055);
        check("ori55_we", {31'd0, w_grf_we}, 32'd1);
        tick();
`else
        check("noint_we", {31'd0, w_grf_we}, 32'd1);
        check("noint_data", w_grf_wdata, 32'h0000_0055);
        tick();
        interrupt = 1'b0;
        #1;
`endif
        check("subu_pc", macroscopic_pc, 32'h0000_3044);
        check("subu_data", w_grf_wdata, 32'hAABB_BAA9);
        tick();
        tick();
        check("bne_pc", macroscopic_pc, 32'h0000_304C);
        check("sll_data", w_grf_wdata, 32'h0001_2340);
        tick();
        check("and_data", w_grf_wdata, 32'h0000_0014);
        tick();
        check("addiu_data", w_grf_wdata, 32'hFFFF_FFFF);
        tick();
        check("lw_data", w_grf_wdata, 32'h0000_DD00);
        tick();
        check("sh_dbe", {28'd0, m_data_byteen}, 32'h0000_000C);
        check("sh_wdata", m_data_wdata, 32'h1234_1234);
        tick();
        tick();
        check("jr_pc", macroscopic_pc, 32'h0000_3024);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
